// File: rtl/oled_init_seq.sv
// rtl/oled_init_seq.sv - PmodOLED (SSD1306) power-up and initialisation sequencer
//
// Purpose:
//   Walks a fixed step list of pin updates, millisecond delays and command-byte
//   sends to bring up the panel, then raises DONE. Command bytes are handed to
//   the existing SPI byte sender through the SPI_EN/SPI_DATA/SPI_FIN handshake.
//
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous reset, active high
//   START    in   begins the sequence when sampled high in IDLE
//   SPI_FIN  in   SPI sender done flag
//   SPI_EN   out  SPI sender request (held until SPI_FIN is sampled high)
//   SPI_DATA out  command byte, stable while SPI_EN=1, holds last value otherwise
//   DC       out  data/command select, always 0 (command mode)
//   RES      out  panel reset, active low
//   VBAT     out  panel bias supply enable, active low
//   VDD      out  logic supply enable, active low
//   DONE     out  sequence complete, sticky until RST

module oled_init_seq #(
  parameter int CLKS_PER_MS   = 12000,
  parameter int VBAT_DELAY_MS = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       SPI_FIN,
  output logic       SPI_EN,
  output logic [7:0] SPI_DATA,
  output logic       DC,
  output logic       RES,
  output logic       VBAT,
  output logic       VDD,
  output logic       DONE
);

  localparam int            PW      = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [7:0]    VBAT_MS = 8'(VBAT_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_DELAY, S_SEND, S_WAIT_CLR, S_FINISH
  } state_t;

  typedef enum logic [2:0] {
    K_VDD_ON, K_RES_LO, K_RES_HI, K_VBAT_ON, K_DELAY, K_SEND, K_FINISH
  } kind_t;

  state_t        state_q;
  logic [4:0]    step_q;
  logic [4:0]    step_d;
  logic [PW-1:0] pre_q;
  logic [6:0]    ms_q;
  logic          spi_en_q;
  logic [7:0]    spi_data_q;
  logic          res_q;
  logic          vbat_q;
  logic          vdd_q;
  logic          done_q;

  // Step decode: kind of action plus its argument (ms count or command byte).
  kind_t      kind;
  logic [7:0] arg;

  always_comb begin
    kind = K_FINISH;
    arg  = 8'h00;
    case (step_q)
      5'd0:  kind = K_VDD_ON;
      5'd1:  begin kind = K_DELAY; arg = 8'd1;     end
      5'd2:  begin kind = K_SEND;  arg = 8'hAE;    end
      5'd3:  kind = K_RES_LO;
      5'd4:  begin kind = K_DELAY; arg = 8'd1;     end
      5'd5:  kind = K_RES_HI;
      5'd6:  begin kind = K_DELAY; arg = 8'd1;     end
      5'd7:  begin kind = K_SEND;  arg = 8'h8D;    end
      5'd8:  begin kind = K_SEND;  arg = 8'h14;    end
      5'd9:  begin kind = K_SEND;  arg = 8'hD9;    end
      5'd10: begin kind = K_SEND;  arg = 8'hF1;    end
      5'd11: kind = K_VBAT_ON;
      5'd12: begin kind = K_DELAY; arg = VBAT_MS;  end
      5'd13: begin kind = K_SEND;  arg = 8'hA1;    end
      5'd14: begin kind = K_SEND;  arg = 8'hC8;    end
      5'd15: begin kind = K_SEND;  arg = 8'hDA;    end
      5'd16: begin kind = K_SEND;  arg = 8'h20;    end
      5'd17: begin kind = K_SEND;  arg = 8'hAF;    end
      default: kind = K_FINISH;
    endcase
  end

  assign step_d = step_q + 5'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      pre_q      <= '0;
      ms_q       <= '0;
      spi_en_q   <= 1'b0;
      spi_data_q <= 8'h00;
      res_q      <= 1'b1;
      vbat_q     <= 1'b1;
      vdd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            step_q  <= '0;
            state_q <= S_EXEC;
          end
        end

        S_EXEC: begin
          case (kind)
            K_VDD_ON:  begin vdd_q  <= 1'b0; step_q <= step_d; end
            K_RES_LO:  begin res_q  <= 1'b0; step_q <= step_d; end
            K_RES_HI:  begin res_q  <= 1'b1; step_q <= step_d; end
            K_VBAT_ON: begin vbat_q <= 1'b0; step_q <= step_d; end
            K_DELAY: begin
              pre_q   <= '0;
              ms_q    <= '0;
              state_q <= S_DELAY;
            end
            K_SEND: begin
              spi_data_q <= arg;
              spi_en_q   <= 1'b1;
              state_q    <= S_SEND;
            end
            default: begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          endcase
        end

        // n ms = n full prescaler wraps; leave on the last wrap of the last ms.
        S_DELAY: begin
          if (pre_q == PRE_MAX) begin
            pre_q <= '0;
            if (ms_q == arg[6:0] - 7'd1) begin
              step_q  <= step_d;
              state_q <= S_EXEC;
            end else begin
              ms_q <= ms_q + 7'd1;
            end
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end

        S_SEND: begin
          if (SPI_FIN) begin
            spi_en_q <= 1'b0;
            state_q  <= S_WAIT_CLR;
          end
        end

        // Sender must drop FIN before another request can be raised.
        S_WAIT_CLR: begin
          if (!SPI_FIN) begin
            step_q  <= step_d;
            state_q <= S_EXEC;
          end
        end

        S_FINISH: begin
          state_q <= S_FINISH;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SPI_EN   = spi_en_q;
  assign SPI_DATA = spi_data_q;
  assign DC       = 1'b0;
  assign RES      = res_q;
  assign VBAT     = vbat_q;
  assign VDD      = vdd_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_oled_init_seq.sv
// tb/tb_oled_init_seq.sv - scoreboard bench for oled_init_seq
module tb_oled_init_seq;

  localparam int CPM = 4;
  localparam int VBD = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       SPI_FIN;
  logic       SPI_EN;
  logic [7:0] SPI_DATA;
  logic       DC;
  logic       RES;
  logic       VBAT;
  logic       VDD;
  logic       DONE;

  always #5 CLK = ~CLK;

  oled_init_seq #(.CLKS_PER_MS(CPM), .VBAT_DELAY_MS(VBD)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SPI_FIN(SPI_FIN),
    .SPI_EN(SPI_EN), .SPI_DATA(SPI_DATA), .DC(DC), .RES(RES),
    .VBAT(VBAT), .VDD(VDD), .DONE(DONE)
  );

  int checks   = 0;
  int errors   = 0;
  int byte_cnt = 0;
  int cyc      = 0;
  int fin_hold = 1;
  logic [7:0] exp_q[$];

  // Hand-computed timing for CPM=4, VBD=3
  localparam int RES_LOW_CYC  = 1 * CPM + 2;    // EXEC(delay step) + delay + EXEC(RES step)
  localparam int VBAT_A1_CYC  = VBD * CPM + 2;  // EXEC(delay step) + delay + EXEC(send step)
  localparam int FIN_EN_CYC   = 2;              // WAIT_CLR sees FIN low, EXEC, SEND

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_full();
    logic [7:0] seq [10];
    seq = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    foreach (seq[i]) exp_q.push_back(seq[i]);
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_done"}, DONE, 1);
  endtask

  function automatic bit follows_send(input logic [7:0] b);
    return (b == 8'h14 || b == 8'hD9 || b == 8'hF1 || b == 8'hC8 ||
            b == 8'hDA || b == 8'h20 || b == 8'hAF);
  endfunction

  // Responsive SPI sender model
  initial begin
    int st;
    int cnt;
    st = 0;
    cnt = 0;
    SPI_FIN = 1'b0;
    forever begin
      @(posedge CLK); #2;
      if (RST) begin
        SPI_FIN = 1'b0; st = 0; cnt = 0;
      end else begin
        case (st)
          0: if (SPI_EN) begin cnt = 1; st = 1; end
          1: begin cnt++; if (cnt == 5) begin SPI_FIN = 1'b1; st = 2; end end
          2: if (!SPI_EN) begin cnt = fin_hold; st = 3; end
          3: begin cnt--; if (cnt == 0) begin SPI_FIN = 1'b0; st = 0; end end
          default: st = 0;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every SPI_EN rise and checks timing
  logic       prev_en   = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_res  = 1'b1;
  logic       prev_vbat = 1'b1;
  logic       prev_fin  = 1'b0;
  int         res_fall  = -1;
  int         vbat_fall = -1;
  int         fin_fall  = -1;

  initial begin
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      cyc++;
      chk("dc_low", DC, 0);
      if (RST) begin
        prev_en = 1'b0; prev_res = 1'b1; prev_vbat = 1'b1; prev_fin = 1'b0;
        res_fall = -1; vbat_fall = -1; fin_fall = -1;
      end else begin
        if (prev_fin && !SPI_FIN) fin_fall = cyc;
        if (SPI_EN && !prev_en) begin
          b = SPI_DATA;
          checks++;
          assert (SPI_FIN == 1'b0) else begin
            errors++;
            $display("FAIL stale_fin: SPI_FIN=%0b at SPI_EN rise, required 0", SPI_FIN);
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h required none", b);
          end else begin
            e = exp_q.pop_front();
            chk("byte", b, e);
          end
          byte_cnt++;
          if (b == 8'hA1 && vbat_fall >= 0) chk("vbat_to_a1", cyc - vbat_fall, VBAT_A1_CYC);
          if (follows_send(b) && fin_fall >= 0) chk("fin_low_to_en", cyc - fin_fall, FIN_EN_CYC);
        end
        if (SPI_EN && prev_en) chk("data_stable", SPI_DATA, prev_data);
        if (DONE) chk("en_after_done", SPI_EN, 0);
        if (prev_res && !RES) res_fall = cyc;
        if (!prev_res && RES && res_fall >= 0) chk("res_low", cyc - res_fall, RES_LOW_CYC);
        if (prev_vbat && !VBAT) vbat_fall = cyc;
        prev_en = SPI_EN; prev_data = SPI_DATA; prev_res = RES;
        prev_vbat = VBAT; prev_fin = SPI_FIN;
      end
    end
  end

  initial begin
    int n;
    RST = 1'b1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset and idle
    @(negedge CLK);
    chk("rst_spi_data", SPI_DATA, 8'h00);
    for (int i = 0; i < 20; i++) begin
      chk("idle_vdd", VDD, 1);
      chk("idle_vbat", VBAT, 1);
      chk("idle_res", RES, 1);
      chk("idle_en", SPI_EN, 0);
      chk("idle_done", DONE, 0);
      @(negedge CLK);
    end

    // Full sequence, responsive sender
    fin_hold = 1;
    byte_cnt = 0;
    push_full();
    pulse_start();
    wait_done("run_a");
    chk("run_a_queue", exp_q.size(), 0);
    chk("run_a_count", byte_cnt, 10);
    chk("run_a_vdd", VDD, 0);
    chk("run_a_vbat", VBAT, 0);
    chk("run_a_res", RES, 1);
    chk("run_a_en", SPI_EN, 0);

    // START after DONE is ignored
    pulse_start();
    repeat (40) @(negedge CLK);
    chk("post_done_count", byte_cnt, 10);
    chk("post_done_done", DONE, 1);

    // Stalled FIN release, START during VBAT delay
    do_reset();
    fin_hold = 10;
    byte_cnt = 0;
    push_full();
    pulse_start();
    n = 0;
    while (VBAT !== 1'b0 && n < 2000) begin @(negedge CLK); n++; end
    chk("run_b_vbat_on", VBAT, 0);
    repeat (3) @(negedge CLK);
    pulse_start();
    wait_done("run_b");
    chk("run_b_queue", exp_q.size(), 0);
    chk("run_b_count", byte_cnt, 10);

    // Reset while D9 is requested
    do_reset();
    fin_hold = 1;
    byte_cnt = 0;
    exp_q.push_back(8'hAE);
    exp_q.push_back(8'h8D);
    exp_q.push_back(8'h14);
    exp_q.push_back(8'hD9);
    pulse_start();
    n = 0;
    while (!(SPI_EN === 1'b1 && SPI_DATA === 8'hD9) && n < 2000) begin @(negedge CLK); n++; end
    chk("run_c_d9_seen", SPI_EN, 1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_en", SPI_EN, 0);
    chk("mid_rst_vdd", VDD, 1);
    chk("mid_rst_vbat", VBAT, 1);
    chk("mid_rst_res", RES, 1);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_queue", exp_q.size(), 0);
    @(posedge CLK); #1 RST = 1'b0;
    byte_cnt = 0;
    push_full();
    pulse_start();
    wait_done("run_c");
    chk("run_c_queue", exp_q.size(), 0);
    chk("run_c_count", byte_cnt, 10);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
